// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction fields and memory handshake in, datapath
// mux selects and enables out. The control unit is the master.
interface multicycle_control_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic       LuOp;
    logic [3:0] ALUOp;
    logic       HiLoWrite;
    logic       mul_busy;
    logic       instr_done;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  OpCode, Funct, mem_ready,
        output PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp,
               ALUOp, HiLoWrite, mul_busy, instr_done, illegal, state
    );

    modport slave (
        output OpCode, Funct, mem_ready,
        input  PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp,
               ALUOp, HiLoWrite, mul_busy, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB/MUL sequencing with a memory
// ready handshake, a parametrised multiply step and illegal-opcode detection.
// Control outputs are decoded from the state register plus the live
// mem_ready/opcode inputs so that handshakes take effect in the same cycle,
// and every output is forced low while rst_n is low.
module multicycle_control #(
    parameter int MULT_CYCLES = 4,
    parameter int ENABLE_MULT = 1,
    parameter int CNT_W       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_MUL = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_rtype, w_j, w_jal, w_jr, w_jalr, w_beq, w_lw, w_sw, w_ialu;
    logic w_mult_fn, w_mult, w_shift, w_legal, w_jump;

    assign w_rtype   = (bus.OpCode == 6'h00);
    assign w_j       = (bus.OpCode == 6'h02);
    assign w_jal     = (bus.OpCode == 6'h03);
    assign w_beq     = (bus.OpCode == 6'h04);
    assign w_lw      = (bus.OpCode == 6'h23);
    assign w_sw      = (bus.OpCode == 6'h2b);
    assign w_ialu    = ((bus.OpCode >= 6'h08) && (bus.OpCode <= 6'h0c)) || (bus.OpCode == 6'h0f);
    assign w_jr      = w_rtype && (bus.Funct == 6'h08);
    assign w_jalr    = w_rtype && (bus.Funct == 6'h09);
    assign w_mult_fn = w_rtype && ((bus.Funct == 6'h18) || (bus.Funct == 6'h19));
    assign w_mult    = w_mult_fn && (ENABLE_MULT != 0);
    assign w_shift   = (bus.Funct == 6'h00) || (bus.Funct == 6'h02) || (bus.Funct == 6'h03);
    // With multiply disabled, mult/multu fall out of the legal R-type set.
    assign w_legal   = (w_rtype && !(w_mult_fn && (ENABLE_MULT == 0)))
                     || w_j || w_jal || w_beq || w_ialu || w_lw || w_sw;
    assign w_jump    = w_j || w_jal || w_jr || w_jalr;

    // State sequencing and MUL down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IF;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IF:  if (bus.mem_ready) r_state <= S_ID;
                S_ID:  r_state <= (w_jump || !w_legal) ? S_IF : S_EX;
                S_EX: begin
                    if (w_mult) begin
                        r_cnt   <= CNT_W'(MULT_CYCLES - 1);
                        r_state <= S_MUL;
                    end else if (w_beq) begin
                        r_state <= S_IF;
                    end else if (w_lw || w_sw) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: if (bus.mem_ready) r_state <= w_sw ? S_IF : S_WB;
                S_WB:  r_state <= S_IF;
                S_MUL: begin
                    if (r_cnt == '0) r_state <= S_IF;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IF;
            endcase
        end
    end

    // Per-state control decode; everything defaults to 0 and stays 0 in reset.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSrc       = 2'b00;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 2'b00;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ExtOp       = 1'b0;
        bus.LuOp        = 1'b0;
        bus.ALUOp       = 4'b0000;
        bus.HiLoWrite   = 1'b0;
        bus.mul_busy    = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal     = 1'b0;
        bus.state       = 3'd0;
        if (rst_n) begin
            bus.state = r_state;
            case (r_state)
                S_IF: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.PCWrite = bus.mem_ready;
                    bus.IRWrite = bus.mem_ready;
                end
                S_ID: begin
                    // Branch target is always precomputed into ALUOut here.
                    bus.ALUSrcB = 2'b11;
                    bus.ExtOp   = 1'b1;
                    if (w_j || w_jal) begin
                        bus.PCWrite    = 1'b1;
                        bus.PCSrc      = 2'b01;
                        bus.instr_done = 1'b1;
                        if (w_jal) begin
                            bus.RegWrite = 1'b1;
                            bus.RegDst   = 2'b10;
                            bus.MemtoReg = 2'b10;
                        end
                    end else if (w_jr || w_jalr) begin
                        bus.PCWrite    = 1'b1;
                        bus.PCSrc      = 2'b10;
                        bus.instr_done = 1'b1;
                        if (w_jalr) begin
                            bus.RegWrite = 1'b1;
                            bus.RegDst   = 2'b01;
                            bus.MemtoReg = 2'b10;
                        end
                    end else if (!w_legal) begin
                        bus.illegal = 1'b1;
                    end
                end
                S_EX: begin
                    bus.ALUOp[3] = bus.OpCode[0];
                    if (w_mult) begin
                        bus.ALUOp[3] = bus.OpCode[0];
                    end else if (w_rtype) begin
                        bus.ALUSrcA    = w_shift ? 2'b10 : 2'b01;
                        bus.ALUOp[2:0] = 3'b010;
                    end else if (w_beq) begin
                        bus.ALUSrcA     = 2'b01;
                        bus.ALUOp[2:0]  = 3'b001;
                        bus.PCWriteCond = 1'b1;
                        bus.PCSrc       = 2'b11;
                        bus.instr_done  = 1'b1;
                    end else if (w_lw || w_sw) begin
                        bus.ALUSrcA = 2'b01;
                        bus.ALUSrcB = 2'b10;
                        bus.ExtOp   = 1'b1;
                    end else begin
                        bus.ALUSrcA = 2'b01;
                        bus.ALUSrcB = 2'b10;
                        bus.ExtOp   = (bus.OpCode == 6'h08) || (bus.OpCode == 6'h0a);
                        bus.LuOp    = (bus.OpCode == 6'h0f);
                        if (bus.OpCode == 6'h0c)
                            bus.ALUOp[2:0] = 3'b100;
                        else if ((bus.OpCode == 6'h0a) || (bus.OpCode == 6'h0b))
                            bus.ALUOp[2:0] = 3'b101;
                    end
                end
                S_MEM: begin
                    bus.IorD       = 1'b1;
                    bus.MemRead    = w_lw;
                    bus.MemWrite   = w_sw;
                    bus.instr_done = w_sw && bus.mem_ready;
                end
                S_WB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                    if (w_lw)         bus.MemtoReg = 2'b01;
                    else if (w_rtype) bus.RegDst   = 2'b01;
                end
                S_MUL: begin
                    bus.mul_busy = 1'b1;
                    if (r_cnt == '0) begin
                        bus.HiLoWrite  = 1'b1;
                        bus.instr_done = 1'b1;
                    end
                end
                default: bus.state = r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table of
// {rst_n, OpCode, Funct, mem_ready, expected outputs} plus hand sequences
// for multiply latency and reset abort during a store.
module tb_multicycle_control;
    logic       clk;
    logic       rst_n;
    logic [5:0] r_op;
    logic [5:0] r_fn;
    logic       r_rdy;

    multicycle_control_if u_if0 ();
    multicycle_control_if u_if1 ();

    assign u_if0.OpCode = r_op;
    assign u_if0.Funct = r_fn;
    assign u_if0.mem_ready = r_rdy;
    assign u_if1.OpCode = r_op;
    assign u_if1.Funct = r_fn;
    assign u_if1.mem_ready = r_rdy;

    multicycle_control #(.MULT_CYCLES(4), .ENABLE_MULT(1), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(u_if0.master));
    multicycle_control #(.MULT_CYCLES(4), .ENABLE_MULT(0), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(u_if1.master));

    // Packed observation word, MSB first.
    logic [29:0] w_obs0, w_obs1;
    assign w_obs0 = {u_if0.PCWrite, u_if0.PCWriteCond, u_if0.PCSrc, u_if0.IorD, u_if0.MemRead,
                     u_if0.MemWrite, u_if0.IRWrite, u_if0.RegWrite, u_if0.RegDst, u_if0.MemtoReg,
                     u_if0.ALUSrcA, u_if0.ALUSrcB, u_if0.ExtOp, u_if0.LuOp, u_if0.ALUOp,
                     u_if0.HiLoWrite, u_if0.mul_busy, u_if0.instr_done, u_if0.illegal, u_if0.state};
    assign w_obs1 = {u_if1.PCWrite, u_if1.PCWriteCond, u_if1.PCSrc, u_if1.IorD, u_if1.MemRead,
                     u_if1.MemWrite, u_if1.IRWrite, u_if1.RegWrite, u_if1.RegDst, u_if1.MemtoReg,
                     u_if1.ALUSrcA, u_if1.ALUSrcB, u_if1.ExtOp, u_if1.LuOp, u_if1.ALUOp,
                     u_if1.HiLoWrite, u_if1.mul_busy, u_if1.instr_done, u_if1.illegal, u_if1.state};

    localparam logic [29:0] ILL  = 30'd1 << 3;
    localparam logic [29:0] DONE = 30'd1 << 4;
    localparam logic [29:0] BUSY = 30'd1 << 5;
    localparam logic [29:0] HILO = 30'd1 << 6;
    localparam logic [29:0] LU   = 30'd1 << 11;
    localparam logic [29:0] EXT  = 30'd1 << 12;
    localparam logic [29:0] RW   = 30'd1 << 21;
    localparam logic [29:0] IRW  = 30'd1 << 22;
    localparam logic [29:0] MW   = 30'd1 << 23;
    localparam logic [29:0] MR   = 30'd1 << 24;
    localparam logic [29:0] IORD = 30'd1 << 25;
    localparam logic [29:0] PCWC = 30'd1 << 28;
    localparam logic [29:0] PCW  = 30'd1 << 29;

    function automatic logic [29:0] st(input int v);    return 30'(v);       endfunction
    function automatic logic [29:0] alu(input int v);   return 30'(v) << 7;  endfunction
    function automatic logic [29:0] srcb(input int v);  return 30'(v) << 13; endfunction
    function automatic logic [29:0] srca(input int v);  return 30'(v) << 15; endfunction
    function automatic logic [29:0] m2r(input int v);   return 30'(v) << 17; endfunction
    function automatic logic [29:0] rdst(input int v);  return 30'(v) << 19; endfunction
    function automatic logic [29:0] pcsrc(input int v); return 30'(v) << 26; endfunction

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic        sel;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic r_both  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instr_done and illegal must never coincide on either instance.
    always @(negedge clk) begin
        if ((u_if0.instr_done && u_if0.illegal) || (u_if1.instr_done && u_if1.illegal))
            r_both <= 1'b1;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic v(input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic sel, input logic [29:0] e);
        vecs.push_back('{nm, rst, op, fn, rdy, sel, e});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [29:0] IF1, IF0, IDB;
    int n_busy, n_hilo, done_at;
    logic hilo_at_done;

    initial begin
        rst_n = 1'b0; r_op = 6'h00; r_fn = 6'h00; r_rdy = 1'b0;
        IF1 = PCW | IRW | MR | srcb(1) | st(0);
        IF0 = MR | srcb(1) | st(0);
        IDB = EXT | srcb(3) | st(1);

        v("reset",      0, 6'h00, 6'h20, 1, 0, 30'd0);
        v("add_if",     1, 6'h00, 6'h20, 1, 0, IF1);
        v("add_id",     1, 6'h00, 6'h20, 1, 0, IDB);
        v("add_ex",     1, 6'h00, 6'h20, 1, 0, srca(1) | alu(2) | st(2));
        v("add_wb",     1, 6'h00, 6'h20, 1, 0, RW | rdst(1) | DONE | st(4));
        v("lw_if_stall",1, 6'h23, 6'h00, 0, 0, IF0);
        v("lw_if",      1, 6'h23, 6'h00, 1, 0, IF1);
        v("lw_id",      1, 6'h23, 6'h00, 1, 0, IDB);
        v("lw_ex",      1, 6'h23, 6'h00, 0, 0, srca(1) | srcb(2) | EXT | alu(8) | st(2));
        v("lw_mem_w1",  1, 6'h23, 6'h00, 0, 0, IORD | MR | st(3));
        v("lw_mem_w2",  1, 6'h23, 6'h00, 0, 0, IORD | MR | st(3));
        v("lw_mem_w3",  1, 6'h23, 6'h00, 0, 0, IORD | MR | st(3));
        v("lw_mem_rdy", 1, 6'h23, 6'h00, 1, 0, IORD | MR | st(3));
        v("lw_wb",      1, 6'h23, 6'h00, 1, 0, RW | m2r(1) | DONE | st(4));
        v("jal_if",     1, 6'h03, 6'h00, 1, 0, IF1);
        v("jal_id",     1, 6'h03, 6'h00, 1, 0, IDB | PCW | pcsrc(1) | RW | rdst(2) | m2r(2) | DONE);
        v("j_if",       1, 6'h02, 6'h00, 1, 0, IF1);
        v("j_id",       1, 6'h02, 6'h00, 1, 0, IDB | PCW | pcsrc(1) | DONE);
        v("jr_if",      1, 6'h00, 6'h08, 1, 0, IF1);
        v("jr_id",      1, 6'h00, 6'h08, 1, 0, IDB | PCW | pcsrc(2) | DONE);
        v("jalr_if",    1, 6'h00, 6'h09, 1, 0, IF1);
        v("jalr_id",    1, 6'h00, 6'h09, 1, 0, IDB | PCW | pcsrc(2) | RW | rdst(1) | m2r(2) | DONE);
        v("beq_if",     1, 6'h04, 6'h00, 1, 0, IF1);
        v("beq_id",     1, 6'h04, 6'h00, 1, 0, IDB);
        v("beq_ex",     1, 6'h04, 6'h00, 1, 0, srca(1) | alu(1) | PCWC | pcsrc(3) | DONE | st(2));
        v("sw_if",      1, 6'h2b, 6'h00, 1, 0, IF1);
        v("sw_id",      1, 6'h2b, 6'h00, 1, 0, IDB);
        v("sw_ex",      1, 6'h2b, 6'h00, 1, 0, srca(1) | srcb(2) | EXT | alu(8) | st(2));
        v("sw_mem",     1, 6'h2b, 6'h00, 1, 0, IORD | MW | DONE | st(3));
        v("addi_if",    1, 6'h08, 6'h00, 1, 0, IF1);
        v("addi_id",    1, 6'h08, 6'h00, 1, 0, IDB);
        v("addi_ex",    1, 6'h08, 6'h00, 1, 0, srca(1) | srcb(2) | EXT | st(2));
        v("addi_wb",    1, 6'h08, 6'h00, 1, 0, RW | DONE | st(4));
        v("slti_if",    1, 6'h0a, 6'h00, 1, 0, IF1);
        v("slti_id",    1, 6'h0a, 6'h00, 1, 0, IDB);
        v("slti_ex",    1, 6'h0a, 6'h00, 1, 0, srca(1) | srcb(2) | EXT | alu(5) | st(2));
        v("slti_wb",    1, 6'h0a, 6'h00, 1, 0, RW | DONE | st(4));
        v("sltiu_if",   1, 6'h0b, 6'h00, 1, 0, IF1);
        v("sltiu_id",   1, 6'h0b, 6'h00, 1, 0, IDB);
        v("sltiu_ex",   1, 6'h0b, 6'h00, 1, 0, srca(1) | srcb(2) | alu(13) | st(2));
        v("sltiu_wb",   1, 6'h0b, 6'h00, 1, 0, RW | DONE | st(4));
        v("andi_if",    1, 6'h0c, 6'h00, 1, 0, IF1);
        v("andi_id",    1, 6'h0c, 6'h00, 1, 0, IDB);
        v("andi_ex",    1, 6'h0c, 6'h00, 1, 0, srca(1) | srcb(2) | alu(4) | st(2));
        v("andi_wb",    1, 6'h0c, 6'h00, 1, 0, RW | DONE | st(4));
        v("lui_if",     1, 6'h0f, 6'h00, 1, 0, IF1);
        v("lui_id",     1, 6'h0f, 6'h00, 1, 0, IDB);
        v("lui_ex",     1, 6'h0f, 6'h00, 1, 0, srca(1) | srcb(2) | LU | alu(8) | st(2));
        v("lui_wb",     1, 6'h0f, 6'h00, 1, 0, RW | DONE | st(4));
        v("sll_if",     1, 6'h00, 6'h00, 1, 0, IF1);
        v("sll_id",     1, 6'h00, 6'h00, 1, 0, IDB);
        v("sll_ex",     1, 6'h00, 6'h00, 1, 0, srca(2) | alu(2) | st(2));
        v("sll_wb",     1, 6'h00, 6'h00, 1, 0, RW | rdst(1) | DONE | st(4));
        v("mult_if",    1, 6'h00, 6'h18, 1, 0, IF1);
        v("mult_id",    1, 6'h00, 6'h18, 1, 0, IDB);
        v("mult_ex",    1, 6'h00, 6'h18, 1, 0, st(2));
        v("mult_mul3",  1, 6'h00, 6'h18, 1, 0, BUSY | st(5));
        v("mult_mul2",  1, 6'h00, 6'h18, 1, 0, BUSY | st(5));
        v("mult_mul1",  1, 6'h00, 6'h18, 1, 0, BUSY | st(5));
        v("mult_mul0",  1, 6'h00, 6'h18, 1, 0, BUSY | HILO | DONE | st(5));
        v("ill_if",     1, 6'h3f, 6'h00, 1, 0, IF1);
        v("ill_id",     1, 6'h3f, 6'h00, 1, 0, IDB | ILL);
        v("ill_back_if",1, 6'h3f, 6'h00, 0, 0, IF0);
        v("nm_reset",   0, 6'h00, 6'h18, 1, 1, 30'd0);
        v("nm_if",      1, 6'h00, 6'h18, 1, 1, IF1);
        v("nm_id",      1, 6'h00, 6'h18, 1, 1, IDB | ILL);
        v("nm_back_if", 1, 6'h00, 6'h18, 0, 1, IF0);

        cyc();
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst;
            r_op  = vecs[i].op;
            r_fn  = vecs[i].fn;
            r_rdy = vecs[i].rdy;
            @(negedge clk);
            chk(vecs[i].name, int'(vecs[i].sel ? w_obs1 : w_obs0), int'(vecs[i].exp));
            cyc();
        end

        // multu on the multiply-enabled instance: count busy/HiLo cycles.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        r_op = 6'h00; r_fn = 6'h19; r_rdy = 1'b1;
        n_busy = 0; n_hilo = 0; done_at = -1; hilo_at_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (u_if0.mul_busy) n_busy++;
            if (u_if0.HiLoWrite) n_hilo++;
            if (u_if0.instr_done) begin
                done_at = c;
                hilo_at_done = u_if0.HiLoWrite;
                cyc();
                break;
            end
            cyc();
        end
        chk("mul_busy_cycles", n_busy, 4);
        chk("hilo_pulses", n_hilo, 1);
        chk("multu_latency", done_at + 1, 7);
        chk("hilo_on_done", int'(hilo_at_done), 1);

        // Reset asserted while sw waits in MEM.
        r_op = 6'h2b; r_fn = 6'h00; r_rdy = 1'b1;
        cyc();
        cyc();
        r_rdy = 1'b0;
        cyc();
        @(negedge clk);
        chk("sw_mem_wait", int'(w_obs0), int'(IORD | MW | st(3)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("sw_rst_abort", int'(w_obs0), 0);
        cyc();
        rst_n = 1'b1;
        r_rdy = 1'b0;
        @(negedge clk);
        chk("if_after_rst_stall", int'(w_obs0), int'(IF0));
        cyc();
        r_rdy = 1'b1;
        @(negedge clk);
        chk("if_after_rst_go", int'(w_obs0), int'(IF1));
        cyc();

        chk("done_illegal_exclusive", int'(r_both), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
